// File: rtl/store_queue_unit.sv
// Store queue unit: buffers store transactions in a small circular queue and
// issues them in order on the TRI request channel. An optional response-counting
// mode limits in-flight stores and lets a drain/flush handshake fence all stores.
module store_queue_unit #(
    parameter int DEPTH           = 4,
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int TID_W           = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int WAIT_RESP       = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ADDR_W-1:0]                    in_addr,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic [1:0]                           in_size,
    input  logic [TID_W-1:0]                     in_tid,
    output logic                                 req_valid,
    input  logic                                 req_ack,
    output logic [4:0]                           req_type,
    output logic [2:0]                           req_size,
    output logic [ADDR_W-1:0]                    req_addr,
    output logic [DATA_W-1:0]                    req_data,
    output logic [TID_W-1:0]                     req_tid,
    input  logic                                 resp_val,
    output logic                                 resp_ack,
    input  logic                                 flush_req,
    output logic                                 flush_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUTSTANDING);
    localparam logic [4:0] TRI_STORE_RQ = 5'b00001;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               err_sticky_q, err_sticky_d;

    // Queue storage: no reset needed, validity is tracked by the pointers.
    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [2:0]         size_mem [DEPTH];
    logic [TID_W-1:0]   tid_mem  [DEPTH];

    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               resp_fire;
    logic [PTR_W-1:0]   wr_idx;
    logic [PTR_W-1:0]   rd_idx;
    logic               drained;

    assign wr_idx = wr_ptr_q[PTR_W-1:0];
    assign rd_idx = rd_ptr_q[PTR_W-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);

    // Request side: issue the head entry; fields are zeroed when the queue is
    // empty so nothing undefined leaks from the uninitialised storage.
    always_comb begin
        req_valid = !empty && ((WAIT_RESP == 0) || (outstanding_q < MAX_OUT_V));
        req_type  = TRI_STORE_RQ;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        req_tid   = '0;
        if (!empty) begin
            req_addr = addr_mem[rd_idx];
            req_data = data_mem[rd_idx];
            req_size = size_mem[rd_idx];
            req_tid  = tid_mem[rd_idx];
        end
    end

    assign push      = in_valid && in_ready;
    assign pop       = req_valid && req_ack;
    assign resp_ack  = (WAIT_RESP != 0) ? (outstanding_q != '0) : 1'b1;
    assign resp_fire = resp_val && resp_ack;
    assign drained   = empty && ((WAIT_RESP == 0) || (outstanding_q == '0));

    // Store the pushed transaction, converting log2 bytes to TRI size.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_idx] <= in_addr;
            data_mem[wr_idx] <= in_data;
            size_mem[wr_idx] <= {1'b0, in_size} + 3'd1;
            tid_mem[wr_idx]  <= in_tid;
        end
    end

    // Pointer, in-flight counter and error flag next-state.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        err_sticky_d  = err_sticky_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (WAIT_RESP != 0) begin
            case ({pop, resp_fire})
                2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
                2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
                default: outstanding_d = outstanding_q;
            endcase
            // A response with nothing in flight is never acked and is flagged.
            if (resp_val && (outstanding_q == '0)) begin
                err_sticky_d = 1'b1;
            end
        end
    end

    // Flush FSM next-state and outputs: drain blocks pushes until everything
    // issued has been answered, then pulses flush_done for one cycle.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            S_RUN: begin
                in_ready = !full;
                if (flush_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                flush_done = 1'b1;
                state_d    = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign outstanding = outstanding_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_store_queue_unit.sv
// Testbench for store_queue_unit: directed stimulus with a scoreboard of
// expected TRI requests checked by an independent issue monitor.
module tb_store_queue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic [63:0] in_data;
    logic [1:0]  in_size;
    logic [1:0]  in_tid;
    logic        req_valid;
    logic        req_ack;
    logic [4:0]  req_type;
    logic [2:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_tid;
    logic        resp_val;
    logic        resp_ack;
    logic        flush_req;
    logic        flush_done;
    logic [1:0]  outstanding;
    logic        err_sticky;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [2:0]  size;
        logic [1:0]  tid;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    store_queue_unit #(
        .DEPTH(4), .ADDR_W(64), .DATA_W(64), .TID_W(2),
        .MAX_OUTSTANDING(2), .WAIT_RESP(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_size(in_size), .in_tid(in_tid),
        .req_valid(req_valid), .req_ack(req_ack), .req_type(req_type),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
        .req_tid(req_tid), .resp_val(resp_val), .resp_ack(resp_ack),
        .flush_req(flush_req), .flush_done(flush_done),
        .outstanding(outstanding), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake on the request channel pops the scoreboard.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && req_valid && req_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got addr 0x%0h expected none", req_addr);
            end else begin
                mon_e = sb.pop_front();
                check("issue_addr", req_addr, mon_e.addr);
                check("issue_data", req_data, mon_e.data);
                check("issue_size", 64'(req_size), 64'(mon_e.size));
                check("issue_tid", 64'(req_tid), 64'(mon_e.tid));
                check("issue_type", 64'(req_type), 64'h1);
                $display("issue addr=0x%0h data=0x%0h size=%0d tid=%0d",
                         req_addr, req_data, req_size, req_tid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [63:0] a, input logic [63:0] d,
                              input logic [1:0] sz, input logic [1:0] t,
                              input logic [2:0] esz);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_size  = sz;
        in_tid   = t;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) begin
                sb.push_back('{a, d, esz, t});
                done = 1'b1;
                $display("push addr=0x%0h size=%0d tid=%0d", a, sz, t);
            end
            tick();
        end
        in_valid = 1'b0;
        check("push_accepted", 64'(done), 64'h1);
    endtask

    // Acknowledge everything and answer every in-flight store until idle.
    task automatic drain_all(input string name);
        req_ack = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && outstanding == 2'd0) break;
            resp_val = (outstanding != 2'd0);
            tick();
        end
        resp_val = 1'b0;
        req_ack  = 1'b0;
        check(name, 64'(sb.size()), 64'h0);
        check({name, "_outstanding"}, 64'(outstanding), 64'h0);
    endtask

    int pulses;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        in_size = '0; in_tid = '0; req_ack = 1'b0; resp_val = 1'b0;
        flush_req = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_req_valid", 64'(req_valid), 64'h0);
        check("rst_outstanding", 64'(outstanding), 64'h0);
        check("rst_err", 64'(err_sticky), 64'h0);
        check("rst_flush_done", 64'(flush_done), 64'h0);
        check("rst_resp_ack", 64'(resp_ack), 64'h0);
        check("rst_req_addr", req_addr, 64'h0);
        rst_n = 1'b1;
        tick();

        // Single store
        req_ack = 1'b0;
        push_store(64'h1000, 64'hDEADBEEF, 2'd2, 2'd1, 3'b011);
        check("single_req_valid", 64'(req_valid), 64'h1);
        check("single_req_size", 64'(req_size), 64'h3);
        check("single_req_tid", 64'(req_tid), 64'h1);
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        check("single_outstanding1", 64'(outstanding), 64'h1);
        check("single_req_valid_low", 64'(req_valid), 64'h0);
        resp_val = 1'b1;
        check("single_resp_ack", 64'(resp_ack), 64'h1);
        tick();
        resp_val = 1'b0;
        check("single_outstanding0", 64'(outstanding), 64'h0);

        // Fill the queue with the request channel stalled
        push_store(64'h00, 64'h1111, 2'd0, 2'd0, 3'b001);
        push_store(64'h08, 64'h2222, 2'd1, 2'd1, 3'b010);
        push_store(64'h10, 64'h3333, 2'd2, 2'd2, 3'b011);
        push_store(64'h18, 64'h4444, 2'd3, 2'd3, 3'b100);
        check("fill_in_ready_low", 64'(in_ready), 64'h0);
        check("fill_req_valid", 64'(req_valid), 64'h1);
        in_valid = 1'b1; in_addr = 64'h20; in_data = 64'h5555; in_size = 2'd3; in_tid = 2'd0;
        tick();
        tick();
        check("fill_hold_in_ready", 64'(in_ready), 64'h0);
        check("fill_hold_addr", req_addr, 64'h0);
        check("fill_hold_size", 64'(req_size), 64'h1);
        req_ack = 1'b1;
        push_store(64'h20, 64'h5555, 2'd3, 2'd0, 3'b100);
        // Two in flight with no responses: capped
        check("fill_cap_outstanding", 64'(outstanding), 64'h2);
        check("fill_cap_req_valid", 64'(req_valid), 64'h0);
        drain_all("fill_drain");

        // Outstanding cap
        push_store(64'h100, 64'hA0, 2'd3, 2'd2, 3'b100);
        push_store(64'h108, 64'hA1, 2'd3, 2'd2, 3'b100);
        push_store(64'h110, 64'hA2, 2'd3, 2'd2, 3'b100);
        req_ack = 1'b1;
        tick();
        tick();
        tick();
        check("cap_outstanding", 64'(outstanding), 64'h2);
        check("cap_req_valid_low", 64'(req_valid), 64'h0);
        resp_val = 1'b1;
        tick();
        resp_val = 1'b0;
        check("cap_after_resp_out", 64'(outstanding), 64'h1);
        check("cap_after_resp_valid", 64'(req_valid), 64'h1);
        tick();
        check("cap_third_issued", 64'(outstanding), 64'h2);
        drain_all("cap_drain");

        // Simultaneous push and pop keep the count
        push_store(64'h400, 64'hB0, 2'd0, 2'd1, 3'b001);
        push_store(64'h408, 64'hB1, 2'd1, 2'd1, 3'b010);
        req_ack = 1'b1;
        push_store(64'h410, 64'hB2, 2'd2, 2'd1, 3'b011);
        req_ack = 1'b0;
        check("sim_pushpop_out", 64'(outstanding), 64'h1);
        push_store(64'h418, 64'hB3, 2'd3, 2'd1, 3'b100);
        check("sim_count3_in_ready", 64'(in_ready), 64'h1);
        push_store(64'h420, 64'hB4, 2'd0, 2'd1, 3'b001);
        check("sim_count4_full", 64'(in_ready), 64'h0);
        // Issue and response in the same cycle keep outstanding
        req_ack = 1'b1;
        resp_val = 1'b1;
        tick();
        req_ack = 1'b0;
        resp_val = 1'b0;
        check("sim_issue_resp_out", 64'(outstanding), 64'h1);
        drain_all("sim_drain");

        // Flush with three queued stores
        push_store(64'h200, 64'hC0, 2'd2, 2'd3, 3'b011);
        push_store(64'h208, 64'hC1, 2'd2, 2'd3, 3'b011);
        push_store(64'h210, 64'hC2, 2'd2, 2'd3, 3'b011);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("flush_in_ready_low", 64'(in_ready), 64'h0);
        req_ack = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            resp_val = (outstanding != 2'd0);
            tick();
            if (flush_done) begin
                pulses++;
                check("flush_done_sb_empty", 64'(sb.size()), 64'h0);
                check("flush_done_outstanding", 64'(outstanding), 64'h0);
                break;
            end
        end
        resp_val = 1'b0;
        req_ack = 1'b0;
        check("flush_pulses", 64'(pulses), 64'h1);
        tick();
        check("flush_done_one_cycle", 64'(flush_done), 64'h0);
        check("flush_in_ready_back", 64'(in_ready), 64'h1);

        // Flush of an empty unit
        flush_req = 1'b1;
        tick();
        check("eflush_drain_done", 64'(flush_done), 64'h0);
        check("eflush_drain_ready", 64'(in_ready), 64'h0);
        tick();
        flush_req = 1'b0;
        check("eflush_done", 64'(flush_done), 64'h1);
        tick();
        check("eflush_after", 64'(flush_done), 64'h0);
        check("eflush_ready", 64'(in_ready), 64'h1);

        // Unexpected response
        resp_val = 1'b1;
        check("err_resp_ack", 64'(resp_ack), 64'h0);
        tick();
        resp_val = 1'b0;
        check("err_sticky_set", 64'(err_sticky), 64'h1);
        tick();
        check("err_sticky_hold", 64'(err_sticky), 64'h1);

        // Reset in the middle of a drain
        push_store(64'h300, 64'hD0, 2'd1, 2'd0, 3'b010);
        push_store(64'h308, 64'hD1, 2'd1, 2'd0, 3'b010);
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        flush_req = 1'b1;
        tick();
        check("mid_drain_ready", 64'(in_ready), 64'h0);
        check("mid_drain_out", 64'(outstanding), 64'h1);
        flush_req = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_out", 64'(outstanding), 64'h0);
        check("rst_mid_req_valid", 64'(req_valid), 64'h0);
        check("rst_mid_in_ready", 64'(in_ready), 64'h1);
        check("rst_mid_err", 64'(err_sticky), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_req_valid", 64'(req_valid), 64'h0);
        resp_val = 1'b1;
        check("post_rst_resp_ack", 64'(resp_ack), 64'h0);
        tick();
        resp_val = 1'b0;
        check("post_rst_err", 64'(err_sticky), 64'h1);

        // Normal operation after reset
        push_store(64'h500, 64'hE0, 2'd3, 2'd2, 3'b100);
        drain_all("final_drain");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
